// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction fetch
// requester and a data load/store requester.
//
// Build option: ARB_STARVE_GUARD_EN
//   When defined, a counter tracks consecutive data grants taken while fetch
//   was waiting. Once that count reaches STARVE_LIMIT, fetch wins the next
//   grant. When the macro is undefined, data always wins over fetch.
//
// Handshake: a request is accepted in the cycle where m_req and m_ready are
// both high in IDLE. That cycle is also the single cycle in which f_gnt or
// d_gnt is high. Requesters hold req and payload stable until their grant,
// so the payload is muxed straight through and never latched. Exactly one
// response (m_rvalid) comes back per accepted request. m_rvalid outside a
// BUSY state is ignored.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_kill,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          f_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   kill_q;
  logic   starve_hit;
  logic   pick_f;
  logic   pick_d;
  logic   idle;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  // Count data grants taken while fetch waits; any fetch grant, or a data
  // grant with no fetch pending, starts the count again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (f_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      if (f_req) starve_cnt <= starve_cnt + 1'b1;
      else       starve_cnt <= '0;
    end
  end

  assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));
`else
  // The limit only matters when the guard is built in.
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve_hit = 1'b0;
`endif

  assign idle = (state == IDLE);

  // Select the winner: data by default, fetch when data is absent or fetch
  // has been starved long enough.
  always_comb begin
    pick_f = f_req && (!d_req || starve_hit);
    pick_d = d_req && !pick_f;
  end

  // Drive the memory port straight from the winner. Fetch never writes.
  always_comb begin
    m_req   = rst_n && idle && (pick_f || pick_d);
    m_we    = pick_d ? d_we : 1'b0;
    m_addr  = pick_d ? d_addr : f_addr;
    m_wdata = pick_d ? d_wdata : '0;
  end

  // A grant pulses only in the accept cycle of the memory handshake.
  always_comb begin
    f_gnt = m_req && m_ready && pick_f;
    d_gnt = m_req && m_ready && pick_d;
  end

  // Route the memory response to whoever owns the outstanding transaction.
  // A fetch response is swallowed if a kill arrived at any point while it
  // was in flight, including the response cycle itself.
  always_comb begin
    f_rvalid = rst_n && (state == BUSY_F) && m_rvalid && !kill_q && !f_kill;
    d_rvalid = rst_n && (state == BUSY_D) && m_rvalid;
    f_rdata  = m_rdata;
    d_rdata  = m_rdata;
    f_stall  = f_req && !(f_gnt || f_rvalid);
  end

  // Transaction FSM plus the sticky kill flag for the in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      kill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (f_gnt) begin
            state  <= BUSY_F;
            kill_q <= f_kill;
          end else if (d_gnt) begin
            state  <= BUSY_D;
          end
        end
        BUSY_F: begin
          if (m_rvalid) begin
            state  <= IDLE;
            kill_q <= 1'b0;
          end else if (f_kill) begin
            kill_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_rvalid) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          kill_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Inputs are
// driven 1 time unit after the rising edge, and outputs are checked on the
// falling edge. Build with +define+ARB_STARVE_GUARD_EN to exercise the
// starvation guard.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_kill;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          f_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = '0; f_kill = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ready = 1; m_rvalid = 0; m_rdata = '0;
  endtask

  initial begin
    int sc;
    logic exp_f;

    rst_n = 0;
    idle_inputs();
    // Reset: combinational outputs quiet, stall follows f_req
    f_req = 1; d_req = 1;
    #2;
    check("rst_m_req", m_req, 0);
    check("rst_f_gnt", f_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_f_stall", f_stall, 1);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1;
    next_cycle();

    // Solo fetch
    f_req = 1; f_addr = 32'h100;
    to_sample();
    check("solo_f_gnt", f_gnt, 1);
    check("solo_m_req", m_req, 1);
    check("solo_m_addr", m_addr, 32'h100);
    check("solo_m_we", m_we, 0);
    check("solo_f_stall_gnt", f_stall, 0);
    next_cycle();
    m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    to_sample();
    check("solo_f_rvalid", f_rvalid, 1);
    check("solo_f_rdata", f_rdata, 32'hDEADBEEF);
    check("solo_f_stall_rsp", f_stall, 0);
    check("solo_busy_m_req", m_req, 0);
    next_cycle();
    m_rvalid = 0; m_ready = 0;
    to_sample();
    check("solo_stall_after", f_stall, 1);
    next_cycle();
    idle_inputs();

    // Contention: data first, fetch after the data response
    f_req = 1; f_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'hAA55;
    to_sample();
    check("cont_d_gnt", d_gnt, 1);
    check("cont_f_gnt0", f_gnt, 0);
    check("cont_m_addr", m_addr, 32'h400);
    check("cont_m_we", m_we, 1);
    check("cont_m_wdata", m_wdata, 32'hAA55);
    check("cont_f_stall", f_stall, 1);
    next_cycle();
    d_req = 0; d_we = 0;
    m_rvalid = 1; m_rdata = 32'h77;
    to_sample();
    check("cont_d_rvalid", d_rvalid, 1);
    check("cont_d_rdata", d_rdata, 32'h77);
    check("cont_f_gnt_rsp", f_gnt, 0);
    check("cont_f_rvalid_none", f_rvalid, 0);
    next_cycle();
    m_rvalid = 0;
    to_sample();
    check("cont_f_gnt", f_gnt, 1);
    check("cont_f_addr", m_addr, 32'h300);
    next_cycle();
    m_rvalid = 1; m_rdata = 32'h55;
    to_sample();
    check("cont_f_rvalid", f_rvalid, 1);
    check("cont_d_rvalid_none", d_rvalid, 0);
    next_cycle();
    idle_inputs();

    // f_kill in IDLE without a grant has no effect on the next fetch
    f_kill = 1; m_ready = 0;
    next_cycle();
    f_kill = 0; m_ready = 1;

    // Kill one cycle after grant
    f_req = 1; f_addr = 32'h180;
    to_sample();
    check("kill_f_gnt", f_gnt, 1);
    next_cycle();
    f_kill = 1; f_addr = 32'h200;
    to_sample();
    check("kill_busy_gnt", f_gnt, 0);
    check("kill_busy_stall", f_stall, 1);
    next_cycle();
    f_kill = 0; m_rvalid = 1; m_rdata = 32'h1234;
    to_sample();
    check("kill_f_rvalid", f_rvalid, 0);
    check("kill_f_stall", f_stall, 1);
    next_cycle();
    m_rvalid = 0;
    to_sample();
    check("kill_next_gnt", f_gnt, 1);
    check("kill_next_addr", m_addr, 32'h200);
    next_cycle();
    m_rvalid = 1; m_rdata = 32'hCAFE;
    to_sample();
    check("kill_clear_rvalid", f_rvalid, 1);
    check("kill_clear_rdata", f_rdata, 32'hCAFE);
    next_cycle();
    idle_inputs();

    // Backpressure: held request, stable address, grant when ready rises
    d_req = 1; d_addr = 32'h500; m_ready = 0;
    for (int i = 0; i < 5; i++) begin
      to_sample();
      check("bp_d_gnt", d_gnt, 0);
      check("bp_m_req", m_req, 1);
      check("bp_m_addr", m_addr, 32'h500);
      next_cycle();
    end
    m_ready = 1;
    to_sample();
    check("bp_d_gnt_rise", d_gnt, 1);
    next_cycle();
    d_req = 0; m_rvalid = 1; m_rdata = 32'h99;
    to_sample();
    check("bp_d_rvalid", d_rvalid, 1);
    check("bp_d_rdata", d_rdata, 32'h99);
    next_cycle();
    idle_inputs();

    // Starvation: both requesters held high
    f_req = 1; f_addr = 32'h800; d_req = 1; d_addr = 32'h900;
    sc = 0;
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_f = (sc == SL);
`else
      exp_f = 1'b0;
`endif
      m_rvalid = 0;
      to_sample();
      check("starve_f_gnt", f_gnt, exp_f);
      check("starve_d_gnt", d_gnt, !exp_f);
      sc = exp_f ? 0 : sc + 1;
      next_cycle();
      m_rvalid = 1; m_rdata = 32'h1000 + t;
      to_sample();
      check("starve_rsp", exp_f ? f_rvalid : d_rvalid, 1);
      next_cycle();
    end
    idle_inputs();

    // Reset in BUSY_D abandons the response
    d_req = 1; d_addr = 32'h600;
    to_sample();
    check("rst_d_gnt_pre", d_gnt, 1);
    next_cycle();
    d_req = 0; f_req = 1;
    #2;
    rst_n = 0;
    m_rvalid = 1; m_rdata = 32'h5A5A;
    #1;
    check("rst_async_d_rvalid", d_rvalid, 0);
    check("rst_async_stall", f_stall, 1);
    next_cycle();
    rst_n = 1; f_req = 0;
    d_req = 1; d_addr = 32'h700; m_rvalid = 1; m_rdata = 32'hBAD;
    to_sample();
    check("rst_stale_d_rvalid", d_rvalid, 0);
    check("rst_idle_d_gnt", d_gnt, 1);
    check("rst_idle_m_addr", m_addr, 32'h700);
    next_cycle();
    d_req = 0; m_rvalid = 1; m_rdata = 32'h11;
    to_sample();
    check("rst_after_d_rvalid", d_rvalid, 1);
    check("rst_after_d_rdata", d_rdata, 32'h11);
    next_cycle();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, name, default, meaning:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits
REQ-002 Ports SHALL be, name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- f_req, in, 1, fetch request valid
- f_addr, in, AW, fetch address (fetchpc)
- f_kill, in, 1, fetch redirect: discard in-flight fetch
- f_gnt, out, 1, fetch request accepted this cycle
- f_rvalid, out, 1, fetch response valid
- f_rdata, out, DW, fetch response data
- f_stall, out, 1, stall to fetch stage
- d_req, in, 1, data request valid
- d_we, in, 1, data write enable
- d_addr, in, AW, data address
- d_wdata, in, DW, data write data
- d_gnt, out, 1, data request accepted
- d_rvalid, out, 1, data response valid, including write acknowledge
- d_rdata, out, DW, data response data
- m_req, out, 1, memory request valid
- m_we, out, 1, memory write enable
- m_addr, out, AW, memory address
- m_wdata, out, DW, memory write data
- m_ready, in, 1, memory accepts request
- m_rvalid, in, 1, memory response valid
- m_rdata, in, DW, memory response data

Function
REQ-003 FSM states SHALL be IDLE, BUSY_F and BUSY_D, with at most one memory transaction outstanding.
REQ-004 In IDLE, m_req SHALL be driven combinationally from the winning requester:
- m_addr, m_we and m_wdata are muxed from the winner.
- m_we is 0 for fetch.
REQ-005 Default priority SHALL be data over fetch.
REQ-006 A grant (f_gnt or d_gnt) SHALL pulse for exactly the cycle in which m_req and m_ready are both high in IDLE.
- The FSM then moves to BUSY_F or BUSY_D.
REQ-007 In BUSY_x:
- m_req SHALL be 0.
- On m_rvalid, the FSM SHALL return to IDLE in the same edge.
- A new grant SHALL be possible no earlier than the next cycle, giving a minimum of 2 cycles per transaction.
REQ-008 Response routing:
- In BUSY_D, m_rvalid SHALL produce d_rvalid with d_rdata equal to m_rdata, in the same cycle (combinational).
- In BUSY_F, m_rvalid SHALL produce f_rvalid, unless the response is killed.
REQ-009 Kill rule. A sticky kill flag SHALL be set by f_kill in BUSY_F, or by f_kill in the same cycle as f_gnt.
- While the flag is set, the BUSY_F response SHALL be consumed with f_rvalid held at 0.
- The flag SHALL clear when that response arrives.
- f_kill in IDLE without f_gnt SHALL have no effect.
REQ-010 f_stall SHALL be 1 whenever f_req is high and neither of the following holds:
- f_gnt is 1, or
- f_rvalid is 1 for an unkilled response.
REQ-011 m_rvalid in IDLE SHALL be ignored and SHALL NOT change state.
REQ-012 Simultaneous m_rvalid and a new request in the same cycle SHALL complete the response only; the new request SHALL be considered in the following IDLE cycle.
REQ-013 Requesters SHALL hold req and payload stable until their grant; the arbiter SHALL NOT latch the payload before the grant.

Reset
REQ-014 rst_n low SHALL asynchronously force:
- state to IDLE
- kill flag to 0
- starvation counter to 0
- all registered outputs to 0
REQ-015 While rst_n is low, combinational outputs SHALL be:
- f_gnt, d_gnt, m_req, f_rvalid and d_rvalid at 0
- f_stall equal to f_req
REQ-016 Reset mid-transaction SHALL abandon the outstanding response; the first m_rvalid after reset release SHALL be ignored per REQ-011.

Configuration
REQ-017 Macro ARB_STARVE_GUARD_EN, when defined, SHALL enable a starvation counter of width clog2(STARVE_LIMIT+1).
- The counter increments on each d_gnt while f_req is high.
- It resets to 0 on f_gnt, and also on any d_gnt with f_req low.
- When the count equals STARVE_LIMIT, fetch SHALL take priority over data for the next grant.
REQ-018 Without ARB_STARVE_GUARD_EN:
- No counter SHALL exist.
- Data SHALL always win over fetch.
- STARVE_LIMIT SHALL be unused.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Solo fetch: f_req=1, f_addr=0x100, d_req=0, m_ready=1, m_rvalid one cycle later with 0xDEADBEEF -> f_gnt for 1 cycle, then f_rvalid=1 with f_rdata=0xDEADBEEF; f_stall=0 only in those two cycles.
- Contention: f_req=d_req=1 in IDLE -> d_gnt first; f_gnt on the first IDLE cycle after d_rvalid.
- Kill: f_kill=1 one cycle after f_gnt; memory returns 0x1234 -> f_rvalid stays 0; next f_req to 0x200 is granted the cycle after the response.
- Starvation with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: f_req and d_req held high -> 4 d_gnt, then f_gnt, then the counter is 0. Without the macro -> no f_gnt while d_req is high.
- Backpressure: m_ready=0 for 5 cycles with d_req=1 -> d_gnt=0 and m_req=1 with a stable m_addr for all 5 cycles; d_gnt in the cycle m_ready rises.
- Reset: rst_n low asynchronously in BUSY_D -> state IDLE immediately; m_rvalid after release -> no d_rvalid.
